// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: registered N-input priority encoder with a sticky
// pending vector and a valid/ready output. Fixed (highest index first) or
// round-robin arbitration can be selected at run time through rr_mode.
module rr_priority_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             rr_mode,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending
);

  // Returns the highest set index of v, or 0 when v is empty.
  function automatic logic [IDX_W-1:0] msb_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // (a + b) mod N, valid for non-power-of-two N as well.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_W+1)'(N)) s = s - (IDX_W+1)'(N);
    return s[IDX_W-1:0];
  endfunction

  logic [IDX_W-1:0] last;      // index of the most recent accept (RR base)
  logic             accept;
  logic             load;
  logic [N-1:0]     acc_mask;
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] base;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] sel_fixed;
  logic [IDX_W-1:0] sel_rr;
  logic [IDX_W-1:0] sel;

  assign accept   = out_valid && out_ready;
  assign load     = !out_valid || accept;
  assign acc_mask = accept ? (N'(1) << out_idx) : '0;
  // Set wins: a request arriving in the cycle its own index is accepted
  // is OR-ed back in after the accepted bit is cleared.
  assign cand     = (pending & ~acc_mask) | req;
  assign base     = accept ? out_idx : last;

  // Rotate cand so that index base-1 lands on the top bit; a plain
  // highest-first encode then realises the descending search b-1, ..., b.
  // NOTE: every always_comb output gets a default before any conditional
  // logic so that no path leaves it unassigned and infers a latch.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = cand[wrap_add(IDX_W'(k), base)];
    end
  end

  assign sel_fixed = msb_idx(cand);
  assign sel_rr    = wrap_add(msb_idx(rot), base);
  assign sel       = rr_mode ? sel_rr : sel_fixed;

  // Sticky pending vector: clear the accepted bit, then merge new requests.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= cand;
    end
  end

  // Output register: reload only when empty or being accepted, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_idx   <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      if (|cand) begin
        out_idx   <= sel;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Round-robin base tracks the last accepted index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= '0;
    end else if (accept) begin
      last <= out_idx;
    end
  end

endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
Parametrised, registered successor to the 4-bit combinational priority encoder. Captures N request lines into a sticky pending vector and presents one encoded index at a time on a valid/ready output. Priority is either fixed (highest index wins) or round-robin, selectable at run time. Sits between interrupt/event sources and a single-consumer dispatcher.

Parameters:
N, 8, number of request lines (N >= 2)
IDX_W, 3, index width; must equal $clog2(N)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N  request pulses/levels; bit i set means source i requests
rr_mode  in  1  0 = fixed priority (highest index first), 1 = round-robin
out_idx  out  IDX_W  encoded index of the presented request
out_valid  out  1  out_idx is valid
out_ready  in  1  consumer accepts out_idx when out_valid && out_ready
pending  out  N  registered sticky request vector

Behaviour:
- Reset (async assert, sync release): pending = 0, out_idx = 0, out_valid = 0, last = 0 (internal RR base). All state is cleared immediately on rst_n low, including mid-transaction.
- accept = out_valid && out_ready; acc_mask = onehot(out_idx) if accept, else 0.
- Pending update each edge: pending <= (pending & ~acc_mask) | req. Set wins: a req bit arriving in the same cycle its index is accepted stays pending.
- Load condition: load = !out_valid || accept.
- Candidates on load: cand = (pending & ~acc_mask) | req, so a new request is visible with 1-cycle latency: req at cycle t with output empty gives out_valid = 1 at t+1.
- Fixed mode (rr_mode = 0): select the highest set index of cand.
- RR mode (rr_mode = 1):
  - Base b = out_idx if accept, else last.
  - Search order is b-1, b-2, ..., 0, N-1, ..., b (mod N). The first set bit of cand wins.
  - On every accept, last <= out_idx.
  - From reset (last = 0), the first choice is N-1, so the first grant matches fixed mode.
- On load: if cand != 0, then out_idx <= selection and out_valid <= 1. Otherwise out_valid <= 0 and out_idx holds its value.
- Hold rule: while out_valid && !out_ready, out_idx and out_valid are stable. New reqs only accumulate into pending.
- rr_mode is sampled only on load cycles. A change never alters a presented index.
- A presented index remains set in pending until accepted.
- No combinational path from req or out_ready to out_idx or out_valid. All outputs are registered.
- Implementation note: the RR search is a rotate-by-base, fixed-priority encode, rotate-back structure. There is no sequential scan, so selection is single-cycle for any N.

Test Plan (N=4, IDX_W=2):
1. Reset: assert rst_n=0 mid-run with pending=1011 and out_valid=1 -> immediately pending=0000, out_valid=0, out_idx=0. After release with req=0, outputs stay 0.
2. Fixed, drain: rr_mode=0, out_ready=1, req=0101 for one cycle (t0) -> t1: idx=2, valid=1. t2: idx=0, valid=1. t3: valid=0, pending=0000.
3. Backpressure: rr_mode=0, req=0001 pulse, out_ready=0. Then req=1000 pulse two cycles later -> idx=0 held valid while pending=1001. Raise out_ready -> next cycle idx=3, then valid=0.
4. RR fairness: rr_mode=1, req=1111 held, out_ready=1 -> accepted sequence 3,2,1,0,3,2.
5. Fixed starvation contrast: the same stimulus with rr_mode=0 -> 3,3,3,3 (set-wins re-arm). Then drop req[3] -> next grant is 2.
6. Set-wins collision: idx=1 presented, out_ready=1 and req=0010 in the same cycle -> pending[1] remains 1 and idx 1 is presented again on the next load (fixed mode, no higher requests).
